id_stage_pipe: RTL and testbench
================================

Name: id_stage_pipe

Overview:
- Pipelined MIPS instruction-decode stage with valid/ready handshakes on both sides, replacing the single-cycle decode/register-file path.
- Decodes the instruction, reads a parametrised register file with write-back bypass, resolves BEQ/BNE/J in ID with a registered redirect, and inserts one bubble on load-use hazards.
- Sits between IF (Ins/nextPC) and EX. It feeds the ID/EX pipeline register and is written by WB.

Parameters:
- XLEN, 32, datapath and register width.
- REG_NUM, 32, number of architectural registers; register 0 is hardwired to zero.
- RA_W, 5, register address width; must equal clog2(REG_NUM).

Ports:
- CLK  in  1  clock, rising-edge.
- RST  in  1  asynchronous, active-low reset.
- if_valid  in  1  Ins/nextPC valid.
- if_ready  out  1  ID accepts this cycle.
- Ins  in  32  instruction.
- nextPC  in  XLEN  PC+4 of Ins.
- wb_we  in  1  write-back enable.
- wb_addr  in  RA_W  write-back register.
- wb_data  in  XLEN  write-back data.
- flush  in  1  squash the ID/EX entry and any incoming instruction.
- ex_ready  in  1  EX accepts this cycle.
- ex_valid  out  1  ID/EX entry valid.
- ex_op  out  6  opcode.
- ex_func  out  6  func field; 0 for non-R instructions.
- ex_rdata1  out  XLEN  rs value.
- ex_rdata2  out  XLEN  rt value.
- ex_imm  out  XLEN  sign-extended imm16.
- ex_dst  out  RA_W  destination register: rd for R-type, rt for LW/ADDI, 0 otherwise.
- ex_regwr  out  1  destination is written.
- ex_memrd  out  1  LW.
- ex_memwr  out  1  SW.
- redirect  out  1  one-cycle pulse: taken branch or jump.
- newPC  out  XLEN  redirect target.

Behaviour:
- Reset (RST=0, asynchronous):
  - ex_valid, redirect, and all ex_* fields are 0; newPC is 0.
  - All registers in the register file are 0.
  - Reset mid-stall or mid-redirect drops all in-flight state.
- Accept condition: accept = if_valid && if_ready.
- if_ready = (!ex_valid || ex_ready) && !hazard. flush forces if_ready to 1 for that cycle; the incoming instruction is discarded.
- Load-use hazard:
  - hazard = ex_valid && ex_memrd && ex_dst!=0 && (ex_dst==rs || (ex_dst==rt && instruction reads rt)).
  - Instructions that read rt: R-type, SW, BEQ, BNE.
  - While hazard holds, nothing is accepted.
  - When the LW leaves (ex_ready=1), the ID/EX register loads a bubble (ex_valid=0). The waiting instruction is accepted on the next cycle.
- Register read:
  - Reads are combinational.
  - Register 0 always reads 0.
  - If wb_we && wb_addr==read address && wb_addr!=0, the read returns wb_data in that same cycle (write-before-read bypass).
  - Writes occur at the rising edge; writes to register 0 are ignored.
- Accepted ALU/memory instruction (R-type ADD/SUB/AND/OR/SLT, ADDI, LW, SW):
  - ID/EX captures all fields at the edge; ex_valid=1 on the next cycle (1-cycle latency).
  - Unknown opcode or func: entry is treated as a NOP, with ex_valid=1 and regwr, memrd, memwr all 0.
- ID/EX hold: when ex_valid && !ex_ready, every ex_* output is held stable.
- Branches and jumps:
  - Accepted BEQ/BNE/J produce no EX entry; ex_valid=0 next cycle unless the register is held.
  - BEQ taken if rdata1==rdata2; BNE taken if they differ.
  - Branch target: newPC = nextPC + (sext(imm16)<<2), modulo 2^XLEN.
  - J is always taken: newPC = {nextPC[31:28], addr26, 2'b00}.
  - If taken, redirect=1 for exactly one cycle after acceptance, with newPC valid in that cycle.
  - No delay slot: the instruction presented while redirect=1 is accepted (if_ready=1) and discarded. IF must present its correct-path instruction from the next cycle.
- flush:
  - At the edge, ex_valid clears and a pending redirect is cancelled.
  - flush has priority over acceptance and hold.
- Simultaneous events: WB write plus hazard stall is legal; the write lands regardless.

Decomposition:
- Opcode and func constants (R_FORM, ADD, SUB, AND, OR, SLT, ADDI, LW, SW, BEQ, BNE, J) live in the shared common_param.vh include.
- Sub-module reg_file_fwd: parametrised XLEN/REG_NUM, 2 read ports plus 1 write port, zero register, write bypass, asynchronous active-low reset.

Test Plan:
- Reset, then ADD (rs=10, rt=11, rd=9) with r10=5, r11=7 preloaded via WB, ex_ready=1 → next cycle ex_valid=1, ex_rdata1=5, ex_rdata2=7, ex_dst=9, ex_func=ADD, ex_regwr=1.
- WB writes r10=0x1234 in the same cycle ADD reading r10 is accepted → ex_rdata1=0x1234. WB writing r0=0xFFFF → r0 still reads 0.
- LW to r11, then ADD reading r11 → exactly one cycle with if_ready=0, then one bubble (ex_valid=0), then ADD accepted. Same sequence with the ADD reading r12 → no stall.
- BEQ with r10=r11=3, imm=7, nextPC=0xE0000000 → redirect=1 for 1 cycle, newPC=0xE000001C. The instruction accepted during redirect is never seen on ex_valid. Repeat with r11=4 → no redirect.
- J addr26=58, nextPC=0xE0000000 → newPC=0xE00000E8, redirect pulse. ex_ready=0 for 3 cycles with ex_valid=1 → outputs stable and if_ready=0.
- flush while an entry is held, and RST low mid-hazard → ex_valid=0 next edge (flush) and immediately (RST); register file zeroed on reset.

Source files
------------

// File: rtl/id_stage_pipe_pkg.sv
// rtl/id_stage_pipe_pkg.sv - MIPS opcode/func constants and instruction classification for the ID stage
package id_stage_pipe_pkg;

  localparam logic [5:0] OP_R_FORM = 6'h00;
  localparam logic [5:0] OP_J      = 6'h02;
  localparam logic [5:0] OP_BEQ    = 6'h04;
  localparam logic [5:0] OP_BNE    = 6'h05;
  localparam logic [5:0] OP_ADDI   = 6'h08;
  localparam logic [5:0] OP_LW     = 6'h23;
  localparam logic [5:0] OP_SW     = 6'h2B;

  localparam logic [5:0] FN_ADD = 6'h20;
  localparam logic [5:0] FN_SUB = 6'h22;
  localparam logic [5:0] FN_AND = 6'h24;
  localparam logic [5:0] FN_OR  = 6'h25;
  localparam logic [5:0] FN_SLT = 6'h2A;

  typedef enum logic [2:0] {
    K_NOP,
    K_ALU_R,
    K_ADDI,
    K_LW,
    K_SW,
    K_BEQ,
    K_BNE,
    K_J
  } kind_t;

  // Anything not recognised collapses to K_NOP so it flows through EX harmlessly.
  function automatic kind_t classify(input logic [5:0] op, input logic [5:0] func);
    kind_t k;
    k = K_NOP;
    case (op)
      OP_R_FORM: begin
        if (func == FN_ADD || func == FN_SUB || func == FN_AND ||
            func == FN_OR  || func == FN_SLT)
          k = K_ALU_R;
      end
      OP_ADDI: k = K_ADDI;
      OP_LW:   k = K_LW;
      OP_SW:   k = K_SW;
      OP_BEQ:  k = K_BEQ;
      OP_BNE:  k = K_BNE;
      OP_J:    k = K_J;
      default: k = K_NOP;
    endcase
    return k;
  endfunction

endpackage

// File: rtl/reg_file_fwd.sv
// rtl/reg_file_fwd.sv - 2R1W register file with hardwired zero register and write-before-read bypass
module reg_file_fwd #(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int RA_W    = 5
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic [RA_W-1:0] raddr1,
  input  logic [RA_W-1:0] raddr2,
  output logic [XLEN-1:0] rdata1,
  output logic [XLEN-1:0] rdata2,
  input  logic            we,
  input  logic [RA_W-1:0] waddr,
  input  logic [XLEN-1:0] wdata
);

  logic [XLEN-1:0] regs [REG_NUM];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
    end else if (we && waddr != '0) begin
      regs[waddr] <= wdata;
    end
  end

  // A same-cycle write-back is visible to the reader so WB needs no extra stall.
  assign rdata1 = (raddr1 == '0) ? '0 :
                  (we && waddr == raddr1) ? wdata : regs[raddr1];
  assign rdata2 = (raddr2 == '0) ? '0 :
                  (we && waddr == raddr2) ? wdata : regs[raddr2];

endmodule

// File: rtl/id_stage_pipe.sv
// rtl/id_stage_pipe.sv - pipelined MIPS decode stage with load-use stall and ID-resolved branches
module id_stage_pipe
  import id_stage_pipe_pkg::*;
#(
  parameter int XLEN    = 32,
  parameter int REG_NUM = 32,
  parameter int RA_W    = 5
) (
  input  logic            CLK,
  input  logic            RST,
  input  logic            if_valid,
  output logic            if_ready,
  input  logic [31:0]     Ins,
  input  logic [XLEN-1:0] nextPC,
  input  logic            wb_we,
  input  logic [RA_W-1:0] wb_addr,
  input  logic [XLEN-1:0] wb_data,
  input  logic            flush,
  input  logic            ex_ready,
  output logic            ex_valid,
  output logic [5:0]      ex_op,
  output logic [5:0]      ex_func,
  output logic [XLEN-1:0] ex_rdata1,
  output logic [XLEN-1:0] ex_rdata2,
  output logic [XLEN-1:0] ex_imm,
  output logic [RA_W-1:0] ex_dst,
  output logic            ex_regwr,
  output logic            ex_memrd,
  output logic            ex_memwr,
  output logic            redirect,
  output logic [XLEN-1:0] newPC
);

  logic [5:0]      op, func;
  logic [RA_W-1:0] rs, rt, rd;
  logic [XLEN-1:0] rdata1, rdata2, imm_ext, target;
  kind_t           kind;
  logic            reads_rt, hazard, hold, take, is_br, taken;
  logic [RA_W-1:0] dst;
  logic            regwr, memrd, memwr;

  assign op      = Ins[31:26];
  assign func    = Ins[5:0];
  assign rs      = Ins[21 +: RA_W];
  assign rt      = Ins[16 +: RA_W];
  assign rd      = Ins[11 +: RA_W];
  assign imm_ext = {{(XLEN-16){Ins[15]}}, Ins[15:0]};
  assign kind    = classify(op, func);

  reg_file_fwd #(.XLEN(XLEN), .REG_NUM(REG_NUM), .RA_W(RA_W)) u_rf (
    .clk    (CLK),
    .rst_n  (RST),
    .raddr1 (rs),
    .raddr2 (rt),
    .rdata1 (rdata1),
    .rdata2 (rdata2),
    .we     (wb_we),
    .waddr  (wb_addr),
    .wdata  (wb_data)
  );

  assign reads_rt = (op == OP_R_FORM) || (op == OP_SW) || (op == OP_BEQ) || (op == OP_BNE);
  assign hazard   = ex_valid && ex_memrd && (ex_dst != '0) &&
                    ((ex_dst == rs) || (reads_rt && ex_dst == rt));
  assign hold     = ex_valid && !ex_ready;

  // During flush or the redirect shadow the incoming word is swallowed, so always ready.
  assign if_ready = flush || redirect || (!hold && !hazard);
  assign take     = if_valid && if_ready && !flush && !redirect;

  assign is_br  = (kind == K_BEQ) || (kind == K_BNE) || (kind == K_J);
  assign taken  = (kind == K_J) ||
                  ((kind == K_BEQ) && (rdata1 == rdata2)) ||
                  ((kind == K_BNE) && (rdata1 != rdata2));
  assign target = (kind == K_J) ? {nextPC[XLEN-1:28], Ins[25:0], 2'b00}
                                : nextPC + (imm_ext << 2);

  always_comb begin
    dst   = '0;
    regwr = 1'b0;
    memrd = 1'b0;
    memwr = 1'b0;
    case (kind)
      K_ALU_R: begin dst = rd; regwr = 1'b1; end
      K_ADDI:  begin dst = rt; regwr = 1'b1; end
      K_LW:    begin dst = rt; regwr = 1'b1; memrd = 1'b1; end
      K_SW:    memwr = 1'b1;
      default: ;
    endcase
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      ex_valid  <= 1'b0;
      ex_op     <= '0;
      ex_func   <= '0;
      ex_rdata1 <= '0;
      ex_rdata2 <= '0;
      ex_imm    <= '0;
      ex_dst    <= '0;
      ex_regwr  <= 1'b0;
      ex_memrd  <= 1'b0;
      ex_memwr  <= 1'b0;
      redirect  <= 1'b0;
      newPC     <= '0;
    end else begin
      redirect <= take && is_br && taken;
      if (take && is_br && taken) newPC <= target;
      if (flush) begin
        ex_valid <= 1'b0;
      end else if (!hold) begin
        if (take && !is_br) begin
          ex_valid  <= 1'b1;
          ex_op     <= op;
          ex_func   <= (op == OP_R_FORM) ? func : 6'd0;
          ex_rdata1 <= rdata1;
          ex_rdata2 <= rdata2;
          ex_imm    <= imm_ext;
          ex_dst    <= dst;
          ex_regwr  <= regwr;
          ex_memrd  <= memrd;
          ex_memwr  <= memwr;
        end else begin
          ex_valid <= 1'b0;
        end
      end
    end
  end

endmodule

// File: tb/tb_id_stage_pipe.sv
// tb/tb_id_stage_pipe.sv - directed and randomized checks of id_stage_pipe against a behavioural model
module tb_id_stage_pipe;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        if_valid = 1'b0;
  logic        if_ready;
  logic [31:0] Ins = '0;
  logic [31:0] nextPC = '0;
  logic        wb_we = 1'b0;
  logic [4:0]  wb_addr = '0;
  logic [31:0] wb_data = '0;
  logic        flush = 1'b0;
  logic        ex_ready = 1'b1;
  logic        ex_valid;
  logic [5:0]  ex_op, ex_func;
  logic [31:0] ex_rdata1, ex_rdata2, ex_imm;
  logic [4:0]  ex_dst;
  logic        ex_regwr, ex_memrd, ex_memwr;
  logic        redirect;
  logic [31:0] newPC;

  id_stage_pipe dut (
    .CLK(CLK), .RST(RST), .if_valid(if_valid), .if_ready(if_ready), .Ins(Ins),
    .nextPC(nextPC), .wb_we(wb_we), .wb_addr(wb_addr), .wb_data(wb_data),
    .flush(flush), .ex_ready(ex_ready), .ex_valid(ex_valid), .ex_op(ex_op),
    .ex_func(ex_func), .ex_rdata1(ex_rdata1), .ex_rdata2(ex_rdata2), .ex_imm(ex_imm),
    .ex_dst(ex_dst), .ex_regwr(ex_regwr), .ex_memrd(ex_memrd), .ex_memwr(ex_memwr),
    .redirect(redirect), .newPC(newPC)
  );

  always #5 CLK = ~CLK;

  typedef struct {
    logic [5:0]  op, func;
    logic [31:0] r1, r2, imm;
    logic [4:0]  dst;
    logic        regwr, memrd, memwr;
  } ent_t;

  int          n_vec = 0;
  int          n_err = 0;
  bit          m_valid, m_redir;
  logic [31:0] m_newpc;
  ent_t        m_ent;
  logic [31:0] m_regs [32];

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h @%0t", tag, got, exp, $time);
    end
  endtask

  function automatic logic [31:0] r_ins(input logic [5:0] fn, input logic [4:0] s, input logic [4:0] t, input logic [4:0] d);
    return {6'h00, s, t, d, 5'h00, fn};
  endfunction
  function automatic logic [31:0] i_ins(input logic [5:0] o, input logic [4:0] s, input logic [4:0] t, input logic [15:0] imm);
    return {o, s, t, imm};
  endfunction

  function automatic logic [31:0] m_read(input logic [4:0] a);
    if (a == 0) return 0;
    if (wb_we && wb_addr == a) return wb_data;
    return m_regs[a];
  endfunction

  function automatic bit m_reads_rt(input logic [31:0] ins);
    return ins[31:26] inside {6'h00, 6'h2B, 6'h04, 6'h05};
  endfunction

  function automatic bit m_ready();
    bit hz;
    hz = m_valid && m_ent.memrd && m_ent.dst != 0 &&
         (m_ent.dst == Ins[25:21] || (m_reads_rt(Ins) && m_ent.dst == Ins[20:16]));
    return flush || m_redir || ((!m_valid || ex_ready) && !hz);
  endfunction

  task automatic m_decode(output ent_t e, output bit is_br, output bit tk, output logic [31:0] tgt);
    logic [5:0] o;
    o = Ins[31:26];
    e.op = o; e.func = 0; e.dst = 0; e.regwr = 0; e.memrd = 0; e.memwr = 0;
    e.r1 = m_read(Ins[25:21]);
    e.r2 = m_read(Ins[20:16]);
    e.imm = {{16{Ins[15]}}, Ins[15:0]};
    is_br = 0; tk = 0;
    tgt = nextPC + e.imm * 4;
    case (o)
      6'h00: begin
        e.func = Ins[5:0];
        if (Ins[5:0] inside {6'h20, 6'h22, 6'h24, 6'h25, 6'h2A}) begin e.dst = Ins[15:11]; e.regwr = 1; end
      end
      6'h08: begin e.dst = Ins[20:16]; e.regwr = 1; end
      6'h23: begin e.dst = Ins[20:16]; e.regwr = 1; e.memrd = 1; end
      6'h2B: e.memwr = 1;
      6'h04: begin is_br = 1; tk = (e.r1 == e.r2); end
      6'h05: begin is_br = 1; tk = (e.r1 != e.r2); end
      6'h02: begin is_br = 1; tk = 1; tgt = (nextPC & 32'hF000_0000) + Ins[25:0] * 4; end
      default: ;
    endcase
  endtask

  task automatic m_step();
    ent_t e; bit is_br, tk, use_it, nr; logic [31:0] tgt;
    m_decode(e, is_br, tk, tgt);
    use_it = if_valid && m_ready() && !flush && !m_redir;
    if (flush) begin
      m_valid = 0; m_redir = 0;
    end else begin
      nr = use_it && is_br && tk;
      if (nr) m_newpc = tgt;
      if (!(m_valid && !ex_ready)) begin
        if (use_it && !is_br) begin m_ent = e; m_valid = 1; end
        else m_valid = 0;
      end
      m_redir = nr;
    end
    if (wb_we && wb_addr != 0) m_regs[wb_addr] = wb_data;
  endtask

  task automatic compare_outputs();
    check_eq("if_ready", if_ready, m_ready());
    check_eq("ex_valid", ex_valid, m_valid);
    check_eq("redirect", redirect, m_redir);
    if (m_redir) check_eq("newPC", newPC, m_newpc);
    if (m_valid) begin
      check_eq("ex_op", ex_op, m_ent.op);
      check_eq("ex_func", ex_func, m_ent.func);
      check_eq("ex_rdata1", ex_rdata1, m_ent.r1);
      check_eq("ex_rdata2", ex_rdata2, m_ent.r2);
      check_eq("ex_imm", ex_imm, m_ent.imm);
      check_eq("ex_dst", ex_dst, m_ent.dst);
      check_eq("ex_ctl", {ex_regwr, ex_memrd, ex_memwr}, {m_ent.regwr, m_ent.memrd, m_ent.memwr});
    end
  endtask

  task automatic cycle(input logic ifv, input logic [31:0] ins, input logic [31:0] npc,
                       input logic we, input logic [4:0] wa, input logic [31:0] wd,
                       input logic fl, input logic exr);
    @(negedge CLK);
    if_valid = ifv; Ins = ins; nextPC = npc;
    wb_we = we; wb_addr = wa; wb_data = wd; flush = fl; ex_ready = exr;
    #1;
    compare_outputs();
    m_step();
  endtask

  task automatic do_reset();
    RST = 1'b0;
    if_valid = 0; wb_we = 0; flush = 0; ex_ready = 1;
    #1;
    check_eq("rst_ex_valid", ex_valid, 0);
    check_eq("rst_redirect", redirect, 0);
    check_eq("rst_newPC", newPC, 0);
    check_eq("rst_fields", {ex_op, ex_dst, ex_regwr, ex_memrd, ex_memwr}, 0);
    check_eq("rst_rdata1", ex_rdata1, 0);
    m_valid = 0; m_redir = 0; m_newpc = 0;
    m_ent = '{op: 0, func: 0, r1: 0, r2: 0, imm: 0, dst: 0, regwr: 0, memrd: 0, memwr: 0};
    for (int i = 0; i < 32; i++) m_regs[i] = 0;
    repeat (2) @(posedge CLK);
    @(negedge CLK);
    RST = 1'b1;
  endtask

  function automatic logic [31:0] rand_ins();
    logic [4:0] s, t, d;
    logic [5:0] fns [5];
    fns = '{6'h20, 6'h22, 6'h24, 6'h25, 6'h2A};
    s = 5'($urandom_range(0, 7)); t = 5'($urandom_range(0, 7)); d = 5'($urandom_range(0, 7));
    case ($urandom_range(0, 11))
      0, 1, 2, 3, 4: return r_ins(fns[$urandom_range(0, 4)], s, t, d);
      5:  return i_ins(6'h08, s, t, 16'($urandom));
      6:  return i_ins(6'h23, s, t, 16'($urandom));
      7:  return i_ins(6'h2B, s, t, 16'($urandom));
      8:  return i_ins(6'h04, s, t, 16'($urandom));
      9:  return i_ins(6'h05, s, t, 16'($urandom));
      10: return {6'h02, 26'($urandom)};
      default: return ($urandom_range(0, 1) == 0) ? r_ins(6'h01, s, t, d) : i_ins(6'h3F, s, t, 16'($urandom));
    endcase
  endfunction

  localparam logic [5:0] ADD = 6'h20;

  initial begin
    do_reset();

    // preload and basic ADD
    cycle(0, 0, 0, 1, 10, 5, 0, 1);
    cycle(0, 0, 0, 1, 11, 7, 0, 1);
    cycle(1, r_ins(ADD, 10, 11, 9), 32'h100, 0, 0, 0, 0, 1);
    @(posedge CLK); #1;
    check_eq("add_valid", ex_valid, 1);
    check_eq("add_rd1", ex_rdata1, 5);
    check_eq("add_rd2", ex_rdata2, 7);
    check_eq("add_dst", ex_dst, 9);
    check_eq("add_func", ex_func, 6'h20);
    check_eq("add_regwr", ex_regwr, 1);

    // write-back bypass and r0
    cycle(1, r_ins(ADD, 10, 11, 9), 32'h104, 1, 10, 32'h1234, 0, 1);
    @(posedge CLK); #1;
    check_eq("bypass_rd1", ex_rdata1, 32'h1234);
    cycle(0, 0, 0, 1, 0, 32'hFFFF, 0, 1);
    cycle(1, r_ins(ADD, 0, 11, 9), 32'h108, 0, 0, 0, 0, 1);
    @(posedge CLK); #1;
    check_eq("r0_zero", ex_rdata1, 0);

    // load-use stall then bubble; then no stall on unrelated register
    cycle(1, i_ins(6'h23, 0, 11, 0), 32'h10C, 0, 0, 0, 0, 1);
    cycle(1, r_ins(ADD, 11, 10, 9), 32'h110, 0, 0, 0, 0, 1);
    check_eq("lu_stall", if_ready, 0);
    cycle(1, r_ins(ADD, 11, 10, 9), 32'h110, 0, 0, 0, 0, 1);
    check_eq("lu_bubble", ex_valid, 0);
    check_eq("lu_ready", if_ready, 1);
    @(posedge CLK); #1;
    check_eq("lu_add_in", ex_valid, 1);
    cycle(1, i_ins(6'h23, 0, 11, 0), 32'h114, 0, 0, 0, 0, 1);
    cycle(1, r_ins(ADD, 12, 10, 9), 32'h118, 0, 0, 0, 0, 1);
    check_eq("no_stall", if_ready, 1);

    // BEQ taken, wrong-path instruction discarded, then not taken
    cycle(0, 0, 0, 1, 10, 3, 0, 1);
    cycle(0, 0, 0, 1, 11, 3, 0, 1);
    cycle(1, i_ins(6'h04, 10, 11, 7), 32'hE000_0000, 0, 0, 0, 0, 1);
    @(posedge CLK); #1;
    check_eq("beq_redir", redirect, 1);
    check_eq("beq_target", newPC, 32'hE000_001C);
    cycle(1, r_ins(ADD, 1, 2, 3), 32'hE000_0004, 0, 0, 0, 0, 1);
    @(posedge CLK); #1;
    check_eq("beq_pulse", redirect, 0);
    check_eq("beq_squash", ex_valid, 0);
    cycle(0, 0, 0, 1, 11, 4, 0, 1);
    cycle(1, i_ins(6'h04, 10, 11, 7), 32'hE000_0000, 0, 0, 0, 0, 1);
    @(posedge CLK); #1;
    check_eq("beq_nt", redirect, 0);

    // J, then hold for three cycles
    cycle(1, {6'h02, 26'd58}, 32'hE000_0000, 0, 0, 0, 0, 1);
    @(posedge CLK); #1;
    check_eq("j_redir", redirect, 1);
    check_eq("j_target", newPC, 32'hE000_00E8);
    cycle(1, r_ins(ADD, 1, 2, 3), 32'h0, 0, 0, 0, 0, 1);
    cycle(1, r_ins(ADD, 10, 11, 9), 32'h200, 0, 0, 0, 0, 1);
    for (int i = 0; i < 3; i++) begin
      cycle(1, r_ins(ADD, 1, 2, 3), 32'h204, 0, 0, 0, 0, 0);
      check_eq("hold_ready", if_ready, 0);
      check_eq("hold_rd2", ex_rdata2, 4);
    end

    // flush a held entry, then reset mid-hazard
    cycle(1, r_ins(ADD, 1, 2, 3), 32'h204, 0, 0, 0, 1, 0);
    @(posedge CLK); #1;
    check_eq("flush_valid", ex_valid, 0);
    cycle(1, i_ins(6'h23, 0, 11, 0), 32'h300, 0, 0, 0, 0, 1);
    cycle(1, r_ins(ADD, 11, 10, 9), 32'h304, 0, 0, 0, 0, 0);
    check_eq("rst_haz_stall", if_ready, 0);
    do_reset();
    cycle(1, r_ins(ADD, 10, 11, 9), 32'h400, 0, 0, 0, 0, 1);
    @(posedge CLK); #1;
    check_eq("rf_zero1", ex_rdata1, 0);
    check_eq("rf_zero2", ex_rdata2, 0);

    // randomized traffic against the model
    for (int i = 0; i < 600; i++) begin
      if (i == 300) begin
        @(negedge CLK);
        do_reset();
      end
      cycle($urandom_range(0, 9) < 8, rand_ins(), $urandom & 32'hFFFF_FFFC,
            1'($urandom_range(0, 1)), 5'($urandom_range(0, 7)), $urandom,
            $urandom_range(0, 19) == 0, $urandom_range(0, 9) < 7);
    end

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
